// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order queue of fetch-time predictions checked against
// the execute-stage outcome; flags mispredicts, redirects fetch, feeds the predictor.
module branch_resolve_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PredValidF,
  input  logic        PredTakenF,
  input  logic [31:0] PredTargetF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallF,
  input  logic        ResolveE,
  input  logic        ActTakenE,
  input  logic [31:0] ActTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        UpdateValid,
  output logic        UpdateTaken,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount,
  output logic        ErrorFlag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  logic          taken_mem_r  [DEPTH];
  logic [31:0]   target_mem_r [DEPTH];
  logic [31:0]   pc4_mem_r    [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic          update_valid_r;
  logic          update_taken_r;
  logic [31:0]   branch_count_r;
  logic [31:0]   miss_count_r;
  logic          error_r;

  logic          empty_s;
  logic          full_s;
  logic          head_taken_s;
  logic [31:0]   head_target_s;
  logic [31:0]   head_pc4_s;
  logic          resolve_s;
  logic          valid_resolve_s;
  logic          mispredict_s;
  logic [31:0]   redirect_s;
  logic          push_req_s;
  logic          push_s;
  logic          overflow_s;
  logic          underflow_s;

  // Head compare, redirect selection and push/pop qualification.
  always_comb begin
    empty_s         = (count_r == CNT_ZERO);
    full_s          = (count_r == FULL_CNT);
    head_taken_s    = taken_mem_r[rd_ptr_r];
    head_target_s   = target_mem_r[rd_ptr_r];
    head_pc4_s      = pc4_mem_r[rd_ptr_r];
    resolve_s       = ResolveE & ~reset;
    valid_resolve_s = resolve_s & ~empty_s;
    mispredict_s    = valid_resolve_s &
                      ((head_taken_s != ActTakenE) |
                       (head_taken_s & ActTakenE & (head_target_s != ActTargetE)));
    if (mispredict_s) begin
      redirect_s = ActTakenE ? ActTargetE : head_pc4_s;
    end else begin
      redirect_s = 32'h0000_0000;
    end
    // A push in the mispredict cycle is on the wrong path and is dropped.
    push_req_s  = PredValidF & ~StallF & ~mispredict_s & ~reset;
    push_s      = push_req_s & (~full_s | valid_resolve_s);
    overflow_s  = push_req_s & full_s & ~valid_resolve_s;
    underflow_s = resolve_s & empty_s;
  end

  // Prediction storage; the head slot may be overwritten while it is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        taken_mem_r[i]  <= 1'b0;
        target_mem_r[i] <= 32'h0000_0000;
        pc4_mem_r[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      taken_mem_r[wr_ptr_r]  <= PredTakenF;
      target_mem_r[wr_ptr_r] <= PredTargetF;
      pc4_mem_r[wr_ptr_r]    <= PCPlus4F;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (mispredict_s) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (valid_resolve_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (push_s)          wr_ptr_r <= wr_ptr_r + PTR_ONE;
      case ({push_s, valid_resolve_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Predictor update strobe, saturating statistics and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_valid_r <= 1'b0;
      update_taken_r <= 1'b0;
      branch_count_r <= 32'h0000_0000;
      miss_count_r   <= 32'h0000_0000;
      error_r        <= 1'b0;
    end else begin
      update_valid_r <= valid_resolve_s;
      update_taken_r <= valid_resolve_s & ActTakenE;
      if (valid_resolve_s && (branch_count_r != 32'hFFFF_FFFF)) begin
        branch_count_r <= branch_count_r + 32'h0000_0001;
      end
      if (mispredict_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'h0000_0001;
      end
      if (overflow_s || underflow_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign MispredictE = mispredict_s;
  assign RedirectPCE = redirect_s;
  assign FlushD      = mispredict_s;
  assign FlushE      = mispredict_s;
  assign UpdateValid = update_valid_r;
  assign UpdateTaken = update_taken_r;
  assign BranchCount = branch_count_r;
  assign MissCount   = miss_count_r;
  assign ErrorFlag   = error_r;

endmodule
